// File: rtl/pipeline_buffer_param.sv
// pipeline_buffer_param: stallable, flushable delay line with run-time tap select and fill tracking
module pipeline_buffer_param #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 32,
   parameter int SELW  = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   input  logic             enable,
   input  logic             flush,
   input  logic [SELW-1:0]  delay_sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [SELW:0]    fill_count,
   output logic             primed
);
   localparam logic [SELW-1:0] TMAX = SELW'(DEPTH - 1);
   localparam logic [SELW:0]   FMAX = (SELW + 1)'(DEPTH);
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [DEPTH-1:0] v_q, v_d;
   logic [SELW:0]    fill_q, fill_d;
   logic [SELW-1:0]  tap;
   always_comb begin
      d_d    = d_q;
      v_d    = v_q;
      fill_d = fill_q;
      if (flush) begin
         d_d    = '{default: '0};
         v_d    = '0;
         fill_d = '0;
      end else if (enable) begin
         d_d[0] = in;
         for (int k = 1; k < DEPTH; k++) d_d[k] = d_q[k-1];
         v_d    = {v_q[DEPTH-2:0], in_valid};
         fill_d = (fill_q == FMAX) ? fill_q : fill_q + 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         d_q    <= '{default: '0};
         v_q    <= '0;
         fill_q <= '0;
      end else begin
         d_q    <= d_d;
         v_q    <= v_d;
         fill_q <= fill_d;
      end
   end
   // out-of-range selects clamp to the last stage rather than wrapping
   assign tap        = (delay_sel > TMAX) ? TMAX : delay_sel;
   assign out        = d_q[tap];
   assign out_valid  = v_q[tap];
   assign fill_count = fill_q;
   assign primed     = fill_q > {1'b0, tap};
endmodule

// File: tb/tb_pipeline_buffer_param.sv
// tb_pipeline_buffer_param: table vectors, hand sequences and randomized model check for two depths
module tb_pipeline_buffer_param;
   logic       clock = 0;
   logic       reset, in_valid, enable, flush;
   logic [1:0] in;
   logic [4:0] delay_sel;
   logic [1:0] o32, o20;
   logic       ov32, ov20, p32, p20;
   logic [5:0] f32, f20;
   int ncmp = 0, nerr = 0;

   pipeline_buffer_param u32 (
      .clock(clock), .reset(reset), .in(in), .in_valid(in_valid), .enable(enable),
      .flush(flush), .delay_sel(delay_sel), .out(o32), .out_valid(ov32),
      .fill_count(f32), .primed(p32));
   pipeline_buffer_param #(.WIDTH(2), .DEPTH(20), .SELW(5)) u20 (
      .clock(clock), .reset(reset), .in(in), .in_valid(in_valid), .enable(enable),
      .flush(flush), .delay_sel(delay_sel), .out(o20), .out_valid(ov20),
      .fill_count(f20), .primed(p20));

   always #5 clock = ~clock;

   // reference: history of accepted words, newest first, plus count of shifts since clear
   logic [2:0] hist[$];
   int         nshift;

   task automatic model_edge();
      if (reset || flush) begin
         hist.delete();
         nshift = 0;
      end else if (enable) begin
         hist.push_front({in_valid, in});
         if (hist.size() > 32) void'(hist.pop_back());
         nshift++;
      end
   endtask

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_depth(int d, logic [1:0] o, logic ov, logic [5:0] f, logic p);
      int t, fill;
      logic [2:0] w;
      t    = (int'(delay_sel) > d - 1) ? d - 1 : int'(delay_sel);
      w    = (t < hist.size()) ? hist[t] : 3'b0;
      fill = (nshift < d) ? nshift : d;
      cmp($sformatf("out_d%0d", d), 32'(o), 32'(w[1:0]));
      cmp($sformatf("out_valid_d%0d", d), 32'(ov), 32'(w[2]));
      cmp($sformatf("fill_d%0d", d), 32'(f), 32'(fill));
      cmp($sformatf("primed_d%0d", d), 32'(p), 32'(fill > t));
   endtask

   task automatic check_model();
      check_depth(32, o32, ov32, f32, p32);
      check_depth(20, o20, ov20, f20, p20);
   endtask

   task automatic drive(logic r, logic fl, logic en, logic iv, logic [1:0] di, logic [4:0] s);
      reset = r; flush = fl; enable = en; in_valid = iv; in = di; delay_sel = s;
   endtask

   task automatic step(logic r, logic fl, logic en, logic iv, logic [1:0] di, logic [4:0] s);
      drive(r, fl, en, iv, di, s);
      @(posedge clock);
      #1;
      model_edge();
      check_model();
   endtask

   typedef struct {
      logic r, fl, en, iv;
      logic [1:0] di;
      logic [4:0] sel;
      logic [1:0] e_out;
      logic e_ov;
      logic [5:0] e_fill;
      logic e_pr;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1, 0, 0, 0, 2'd0, 5'd3,  2'd0, 0, 6'd0, 0};
      tbl[1]  = '{0, 0, 1, 1, 2'd1, 5'd3,  2'd0, 0, 6'd1, 0};
      tbl[2]  = '{0, 0, 1, 1, 2'd2, 5'd3,  2'd0, 0, 6'd2, 0};
      tbl[3]  = '{0, 0, 1, 1, 2'd3, 5'd3,  2'd0, 0, 6'd3, 0};
      tbl[4]  = '{0, 0, 1, 1, 2'd0, 5'd3,  2'd1, 1, 6'd4, 1};
      tbl[5]  = '{0, 0, 0, 1, 2'd3, 5'd3,  2'd1, 1, 6'd4, 1};
      tbl[6]  = '{0, 0, 1, 0, 2'd2, 5'd2,  2'd3, 1, 6'd5, 1};
      tbl[7]  = '{0, 0, 1, 1, 2'd1, 5'd2,  2'd0, 1, 6'd6, 1};
      tbl[8]  = '{0, 0, 1, 0, 2'd0, 5'd2,  2'd2, 0, 6'd7, 1};
      tbl[9]  = '{0, 1, 1, 1, 2'd3, 5'd0,  2'd0, 0, 6'd0, 0};
      tbl[10] = '{0, 0, 1, 1, 2'd3, 5'd0,  2'd3, 1, 6'd1, 1};
      tbl[11] = '{0, 0, 1, 1, 2'd2, 5'd31, 2'd0, 0, 6'd2, 0};
      hist.delete();
      nshift = 0;
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].r, tbl[i].fl, tbl[i].en, tbl[i].iv, tbl[i].di, tbl[i].sel);
         @(posedge clock);
         #1;
         cmp($sformatf("tbl%0d_out", i), 32'(o32), 32'(tbl[i].e_out));
         cmp($sformatf("tbl%0d_valid", i), 32'(ov32), 32'(tbl[i].e_ov));
         cmp($sformatf("tbl%0d_fill", i), 32'(f32), 32'(tbl[i].e_fill));
         cmp($sformatf("tbl%0d_primed", i), 32'(p32), 32'(tbl[i].e_pr));
      end

      // re-tap immediately: words 1,2,3,0 then sel 3 -> 1, sel 0 -> 0 in the same cycle
      step(1, 0, 0, 0, 0, 3);
      step(0, 0, 1, 1, 1, 3);
      step(0, 0, 1, 1, 2, 3);
      step(0, 0, 1, 1, 3, 3);
      step(0, 0, 1, 1, 0, 3);
      cmp("retap_sel3", 32'(o32), 32'd1);
      delay_sel = 0;
      #1;
      cmp("retap_sel0", 32'(o32), 32'd0);
      check_model();

      // stall after two words: state frozen, first word emerges 2 enabled edges later
      step(1, 0, 0, 0, 0, 3);
      step(0, 0, 1, 1, 1, 3);
      step(0, 0, 1, 1, 2, 3);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 1, 3, 3);
         cmp("stall_fill", 32'(f32), 32'd2);
      end
      step(0, 0, 1, 1, 3, 3);
      step(0, 0, 1, 1, 0, 3);
      cmp("stall_emerge", {30'd0, ov32, 1'b0} | 32'(o32), 32'd3);

      // long latency from reset, clamp on the 20-deep build, flush from full
      step(1, 0, 0, 0, 0, 31);
      step(1, 0, 0, 0, 0, 31);
      for (int i = 0; i < 40; i++) step(0, 0, 1, 1, 2'(i), 31);
      cmp("full_fill", 32'(f32), 32'd32);
      step(0, 1, 1, 1, 3, 31);
      cmp("flush_fill", 32'(f32), 32'd0);
      for (int i = 0; i < 34; i++) step(0, 0, 1, 0, 2'(i), 31);
      cmp("flush_no_leak", 32'(ov32), 32'd0);

      // reset mid-stream: nothing queued before it may emerge
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 2'(i + 1), 5);
      step(1, 0, 1, 1, 3, 5);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 5);

      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
              1'($urandom), 2'($urandom), 5'($urandom));
         delay_sel = 5'($urandom);
         #1;
         check_model();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
